// File: rtl/inst_fetch_if.sv
// Instruction-memory front end for the fetch stage: issues PC requests to an
// in-order, variable-latency memory, returns instructions in order and drops stale ones after a redirect.
module inst_fetch_if #(
    parameter int MAX_OUTST = 2,
    parameter int CW        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] inst_add,
    input  logic        flush,
    output logic        inst_rready,
    output logic        vinst,
    output logic [31:0] inst,
    output logic        mem_req,
    output logic [31:0] mem_add,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

    if (MAX_OUTST < 1 || MAX_OUTST > 7 || MAX_OUTST >= (1 << CW)) begin : g_bad_param
        $error("inst_fetch_if: MAX_OUTST out of range for CW");
    end

    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic          r_pend_v;
    logic [31:0]   r_pend_add;

    logic          w_slot_free;
    logic          w_cand_v;
    logic          w_cand_from_req;
    logic [31:0]   w_cand_add;
    logic          w_issue;
    logic          w_consume;
    logic [CW-1:0] w_issue_c;
    logic [CW-1:0] w_consume_c;
    logic [CW-1:0] w_outst_next;
    logic [CW-1:0] w_drop_next;

    assign w_slot_free = (r_outst < MAX_C);
    assign inst_rready = !reset && !r_pend_v && w_slot_free;

    // A redirect target overrides (and discards) whatever sits in the skid register.
    always_comb begin
        w_cand_v        = 1'b0;
        w_cand_from_req = 1'b0;
        w_cand_add      = 32'd0;
        if (flush && req) begin
            w_cand_v        = 1'b1;
            w_cand_from_req = 1'b1;
            w_cand_add      = inst_add;
        end else if (r_pend_v) begin
            w_cand_v        = 1'b1;
            w_cand_add      = r_pend_add;
        end else if (req) begin
            w_cand_v        = 1'b1;
            w_cand_from_req = 1'b1;
            w_cand_add      = inst_add;
        end
    end

    assign mem_req     = !reset && w_cand_v && (w_slot_free || mem_rvalid);
    assign mem_add     = {w_cand_add[31:2], 2'b00};
    assign w_issue     = mem_req && mem_gnt;
    assign w_consume   = mem_rvalid && (r_outst != '0);
    assign w_issue_c   = {{(CW-1){1'b0}}, w_issue};
    assign w_consume_c = {{(CW-1){1'b0}}, w_consume};

    assign vinst = !reset && w_consume && (r_drop == '0) && !flush;
    assign inst  = vinst ? mem_rdata : 32'd0;

    assign w_outst_next = r_outst + w_issue_c - w_consume_c;

    // On redirect every surviving in-flight entry becomes stale; the new target is excluded.
    always_comb begin
        if (flush) begin
            w_drop_next = r_outst - w_consume_c;
        end else if (w_consume && (r_drop != '0)) begin
            w_drop_next = r_drop - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_drop_next = r_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outst    <= '0;
            r_drop     <= '0;
            r_pend_v   <= 1'b0;
            r_pend_add <= 32'd0;
        end else begin
            r_outst <= w_outst_next;
            r_drop  <= w_drop_next;
            if (w_cand_from_req && !w_issue) begin
                r_pend_v   <= 1'b1;
                r_pend_add <= inst_add;
            end else if (w_issue) begin
                r_pend_v   <= 1'b0;
            end
        end
    end

    a_drop_le_outst: assert property (@(posedge clk) disable iff (reset) r_drop <= r_outst);

endmodule
